// File: rtl/my_switch_btn_reader.sv
// Switch / push-button input peripheral: two-flop synchronisers, per-bit
// debounce, sticky button rising-edge flags with write-one-to-clear,
// an interrupt output and a registered one-cycle-latency read port.
module my_switch_btn_reader #(
    parameter int SW_W      = 16,
    parameter int BTN_W     = 5,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]  btn_in,
    input  logic              re,
    input  logic              sel,
    input  logic              we,
    input  logic [15:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq
);

    // Switches occupy the low bits, buttons the high bits of the debounced vector.
    localparam int N = SW_W + BTN_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N-1:0]      raw_s;
    logic [N-1:0]      s1_r;
    logic [N-1:0]      s2_r;
    logic [N-1:0]      stable_r;
    logic [N-1:0]      stable_nxt_s;
    logic [CNT_W-1:0]  cnt_r     [N];
    logic [CNT_W-1:0]  cnt_nxt_s [N];

    logic [BTN_W-1:0]  btn_stable_s;
    logic [BTN_W-1:0]  btn_stable_nxt_s;
    logic [BTN_W-1:0]  rise_s;
    logic [BTN_W-1:0]  clr_s;
    logic [BTN_W-1:0]  edge_r;
    logic [BTN_W-1:0]  edge_nxt_s;
    logic              irq_r;
    logic [31:0]       rd_s;
    logic [31:0]       rdata_r;

    assign raw_s            = {btn_in, sw_in};
    assign btn_stable_s     = stable_r[N-1 -: BTN_W];
    assign btn_stable_nxt_s = stable_nxt_s[N-1 -: BTN_W];

    // Two-flop synchroniser for every raw pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= {N{1'b0}};
            s2_r <= {N{1'b0}};
        end else begin
            s1_r <= raw_s;
            s2_r <= s1_r;
        end
    end

    // Per-bit debounce: the synchronised value must differ from the stable
    // value for DB_CYCLES consecutive cycles before it is accepted.
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (s2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] < CNT_MAX) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else begin
                stable_nxt_s[i] = s2_r[i];
                cnt_nxt_s[i]    = CNT_ZERO;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_r <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            stable_r <= stable_nxt_s;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Edge flags: a new press sets its flag even when the same bit is being cleared.
    always_comb begin
        rise_s = btn_stable_nxt_s & ~btn_stable_s;
        if (we) begin
            clr_s = wdata[BTN_W-1:0];
        end else begin
            clr_s = {BTN_W{1'b0}};
        end
        edge_nxt_s = (edge_r & ~clr_s) | rise_s;
    end

    // Sticky flags and the interrupt, both held in flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_r <= {BTN_W{1'b0}};
            irq_r  <= 1'b0;
        end else begin
            edge_r <= edge_nxt_s;
            irq_r  <= |edge_nxt_s;
        end
    end

    // Read mux selects current (pre-update) register contents.
    always_comb begin
        rd_s = 32'h0000_0000;
        if (sel) begin
            rd_s[16 +: BTN_W] = edge_r;
            rd_s[0 +: BTN_W]  = btn_stable_s;
        end else begin
            rd_s[0 +: SW_W]   = stable_r[SW_W-1:0];
        end
    end

    // Registered read data; holds between read strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= rd_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;
    assign irq   = irq_r;

endmodule

// File: tb/tb_my_switch_btn_reader.sv
// Bench for my_switch_btn_reader: directed scenarios plus randomized pin and
// bus traffic, compared every cycle against a sample-history reference model.
module tb_my_switch_btn_reader;

    localparam int SW_W  = 16;
    localparam int BTN_W = 5;
    localparam int DB    = 4;
    localparam int N     = SW_W + BTN_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [SW_W-1:0]   sw_in = 16'h0000;
    logic [BTN_W-1:0]  btn_in = 5'b00000;
    logic              re = 1'b0;
    logic              sel = 1'b0;
    logic              we = 1'b0;
    logic [15:0]       wdata = 16'h0000;
    logic [31:0]       rdata;
    logic              irq;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [N-1:0]      pin_q[$];
    logic [N-1:0]      s2_q[$];
    logic [N-1:0]      m_stable = '0;
    logic [BTN_W-1:0]  m_edge = '0;
    logic [31:0]       m_rdata = 32'h0;

    my_switch_btn_reader #(
        .SW_W(SW_W), .BTN_W(BTN_W), .DB_CYCLES(DB), .CNT_W(20)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .btn_in(btn_in),
        .re(re), .sel(sel), .we(we), .wdata(wdata),
        .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    // The pin value seen after synchronisation is the pin sampled two edges
    // earlier; a bit is accepted once its last DB synchronised values all
    // differ from the accepted value.
    task automatic model_step();
        logic [N-1:0]     s2_now;
        logic [N-1:0]     nstab;
        logic [BTN_W-1:0] ob, nb, clr;
        bit               all_diff;
        if (rst) begin
            pin_q.delete();
            s2_q.delete();
            m_stable = '0;
            m_edge   = '0;
            m_rdata  = 32'h0;
        end else begin
            s2_now = (pin_q.size() >= 2) ? pin_q[pin_q.size()-2] : '0;
            s2_q.push_back(s2_now);
            if (s2_q.size() > DB) void'(s2_q.pop_front());
            nstab = m_stable;
            if (s2_q.size() == DB) begin
                for (int b = 0; b < N; b++) begin
                    all_diff = 1'b1;
                    foreach (s2_q[j]) if (s2_q[j][b] == m_stable[b]) all_diff = 1'b0;
                    if (all_diff) nstab[b] = s2_now[b];
                end
            end
            ob = m_stable[N-1 -: BTN_W];
            nb = nstab[N-1 -: BTN_W];
            if (re) begin
                if (sel) m_rdata = {11'd0, m_edge, 11'd0, ob};
                else     m_rdata = {16'd0, m_stable[SW_W-1:0]};
            end
            clr      = we ? wdata[BTN_W-1:0] : '0;
            m_edge   = (m_edge & ~clr) | (nb & ~ob);
            m_stable = nstab;
            pin_q.push_back({btn_in, sw_in});
            if (pin_q.size() > 2) void'(pin_q.pop_front());
        end
    endtask

    // One clock: model the edge, let the DUT take it, compare at the falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_eq("rdata_model", rdata, m_rdata);
        check_eq("irq_model", {31'd0, irq}, {31'd0, |m_edge});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset state.
        cycles(2);
        check_eq("reset_rdata", rdata, 32'h0);
        check_eq("reset_irq", {31'd0, irq}, 32'h0);
        rst = 1'b0;

        // 1: switch change becomes readable after DB+2 edges plus read latency.
        sw_in = 16'hA5A5; re = 1'b1; sel = 1'b0;
        cycles(6);
        check_eq("sw_before_stable", rdata, 32'h0);
        cycle();
        check_eq("sw_after_stable", rdata, 32'h0000A5A5);

        // 2: a short button glitch is filtered.
        btn_in = 5'b00100; cycles(3);
        btn_in = 5'b00000; cycles(8);
        sel = 1'b1; cycle();
        check_eq("glitch_status", rdata, 32'h0);
        check_eq("glitch_irq", {31'd0, irq}, 32'h0);

        // 3: press, flag appears on edge 6 and survives release.
        re = 1'b0; btn_in = 5'b00001;
        cycles(5);
        check_eq("press_irq_early", {31'd0, irq}, 32'h0);
        cycle();
        check_eq("press_irq_set", {31'd0, irq}, 32'h1);
        cycles(4);
        btn_in = 5'b00000; cycles(10);
        re = 1'b1; sel = 1'b1; cycle();
        check_eq("flag_after_release", rdata, 32'h00010000);
        re = 1'b0;

        // 4: write-one-to-clear, then clear coinciding with a new rise.
        we = 1'b1; wdata = 16'h0001; cycle();
        we = 1'b0; wdata = 16'h0000;
        check_eq("w1c_irq", {31'd0, irq}, 32'h0);
        btn_in = 5'b00001; cycles(5);
        we = 1'b1; wdata = 16'h0001; cycle();
        we = 1'b0; wdata = 16'h0000;
        check_eq("set_wins_irq", {31'd0, irq}, 32'h1);

        // 5: read together with clear returns pre-clear flags.
        cycles(2);
        re = 1'b1; sel = 1'b1; we = 1'b1; wdata = 16'hFFFF; cycle();
        check_eq("read_with_clear", rdata, 32'h00010001);
        we = 1'b0; wdata = 16'h0000; cycle();
        check_eq("read_after_clear", rdata, 32'h00000001);

        // 6: reset in the middle of a switch debounce.
        sel = 1'b0; sw_in = 16'h00FF; cycles(3);
        rst = 1'b1; #1;
        check_eq("rst_async_rdata", rdata, 32'h0);
        check_eq("rst_async_irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        cycles(2);
        rst = 1'b0;
        cycles(6);
        check_eq("rst_requal_early", rdata, 32'h0);
        cycle();
        check_eq("rst_requal_done", rdata, 32'h000000FF);

        // Randomized traffic.
        for (int it = 0; it < 600; it++) begin
            int hold;
            if ($urandom_range(0, 3) == 0) sw_in = SW_W'($urandom);
            if ($urandom_range(0, 2) == 0) btn_in = BTN_W'($urandom);
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                re    = 1'($urandom);
                sel   = 1'($urandom);
                we    = ($urandom_range(0, 5) == 0);
                wdata = 16'($urandom);
                rst   = ($urandom_range(0, 150) == 0);
                cycle();
                rst   = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
